// File: rtl/ram_prog_loader_if.sv
// Byte-stream input handshake and SAP-1 RAM/address-mux programming lines.
interface ram_prog_loader_if;
  logic       start;
  logic       abort;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       mux_select;
  logic [3:0] prog_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       busy;
  logic       done;

  modport master (
    output start, abort, byte_valid, byte_data,
    input  byte_ready, mux_select, prog_addr, ram_data, ram_we, busy, done
  );

  modport slave (
    input  start, abort, byte_valid, byte_data,
    output byte_ready, mux_select, prog_addr, ram_data, ram_we, busy, done
  );
endinterface

// File: rtl/ram_prog_loader.sv
// Program-mode sequencer: writes NUM_WORDS streamed bytes into SAP-1 RAM through
// the a-side of the 74157 address mux, then returns the mux to the MAR.
module ram_prog_loader #(
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned WE_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  ram_prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_e;

  localparam logic [3:0] LAST_ADDR = 4'(NUM_WORDS - 1);
  localparam logic [1:0] WE_LAST   = 2'(WE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [1:0] we_cnt_q, we_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      we_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_cnt_q <= we_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_cnt_d = we_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_WAIT_BYTE;
          addr_d  = '0;
        end
      end
      S_WAIT_BYTE: begin
        if (bus.byte_valid) begin
          state_d  = S_WRITE;
          data_d   = bus.byte_data;
          we_cnt_d = '0;
        end
      end
      S_WRITE: begin
        if (we_cnt_q == WE_LAST) begin
          state_d = S_NEXT;
        end else begin
          we_cnt_d = we_cnt_q + 2'd1;
        end
      end
      S_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 4'd1;
          state_d = S_WAIT_BYTE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides any handshake or advance decided above.
    if (state_q != S_IDLE && bus.abort) begin
      state_d  = S_IDLE;
      addr_d   = '0;
      data_d   = '0;
      we_cnt_d = '0;
    end
  end

  always_comb begin
    bus.mux_select = (state_q == S_IDLE);
    bus.byte_ready = (state_q == S_WAIT_BYTE);
    bus.ram_we     = (state_q == S_WRITE);
    bus.busy       = (state_q != S_IDLE);
    bus.done       = (state_q == S_DONE);
    bus.prog_addr  = addr_q;
    bus.ram_data   = data_q;
  end

endmodule
